// File: rtl/rom_cmd_seq.sv
// rom_cmd_seq
//   Runs a rom_seq instance as a command script. On start it rewinds the ROM,
//   then fetches one word at a time and executes it:
//     opcode 00 SEND  - present payload on out_data with valid/ready handshake
//     opcode 01 WAIT  - idle for payload+1 ticks
//     opcode 10 END   - stop
//     opcode 11       - reserved: flag error and stop
//   Running off the end of the ROM (rom_empty) is an implicit END.
//
//   Optional feature macro: ROM_CMD_SEQ_PRESCALE_EN
//     When defined, a WAIT tick is issued every PRESCALE clocks instead of
//     every clock, so WAIT n lasts (n+1)*PRESCALE cycles.
//
// Ports
//   clock      in   system clock
//   reset      in   asynchronous active-high reset
//   start      in   begin/restart the script (only honoured in IDLE/DONE)
//   rom_rewind out  one-cycle pulse to rom_seq.reset
//   rom_get    out  fetch strobe to rom_seq.get
//   rom_empty  in   rom_seq.empty
//   rom_data   in   rom_seq.out, valid the cycle after an accepted get
//   out_data   out  SEND payload (W-2 bits)
//   out_valid  out  SEND payload valid
//   out_ready  in   target accepts payload
//   busy       out  high in every state except IDLE/DONE
//   done       out  high while in DONE
//   error      out  sticky reserved-opcode flag, cleared by reset or start
module rom_cmd_seq #(
  parameter int W        = 16,
  parameter int PRESCALE = 1000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  output logic         rom_rewind,
  output logic         rom_get,
  input  logic         rom_empty,
  input  logic [W-1:0] rom_data,
  output logic [W-3:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int P = W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REWIND,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state, state_next;
  logic [P-1:0]   out_data_next;
  logic           out_valid_next;
  logic           error_next;
  logic           done_next;
  logic [P-1:0]   wait_cnt, wait_cnt_next;
  logic           tick;

  logic [1:0]     opcode;
  logic [P-1:0]   payload;

  assign opcode  = rom_data[W-1:W-2];
  assign payload = rom_data[P-1:0];

`ifdef ROM_CMD_SEQ_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt, pre_cnt_next;

  // Tick when the prescaler is about to wrap back to 0.
  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  always_comb begin
    pre_cnt_next = pre_cnt;
    if (state == S_DECODE) begin
      pre_cnt_next = '0;
    end else if (state == S_WAIT) begin
      pre_cnt_next = tick ? '0 : pre_cnt + PW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt_next;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Strobes decoded straight from state. rom_get is qualified by rom_empty so
  // a get is never issued against an exhausted ROM.
  assign rom_rewind = (state == S_REWIND);
  assign rom_get    = (state == S_FETCH) && !rom_empty;
  assign busy       = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    state_next     = state;
    out_data_next  = out_data;
    out_valid_next = out_valid;
    wait_cnt_next  = wait_cnt;
    error_next     = error;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = S_REWIND;
          error_next = 1'b0;
        end
      end

      S_REWIND: state_next = S_FETCH;

      S_FETCH: begin
        state_next = rom_empty ? S_DONE : S_DECODE;
      end

      S_DECODE: begin
        case (opcode)
          2'b00: begin
            out_data_next  = payload;
            out_valid_next = 1'b1;
            state_next     = S_SEND;
          end
          2'b01: begin
            wait_cnt_next = payload;
            state_next    = S_WAIT;
          end
          2'b10: state_next = S_DONE;
          default: begin
            error_next = 1'b1;
            state_next = S_DONE;
          end
        endcase
      end

      S_SEND: begin
        // out_valid is always high in SEND, so ready alone completes it.
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = S_FETCH;
        end
      end

      S_WAIT: begin
        if (tick) begin
          if (wait_cnt == '0) begin
            state_next = S_FETCH;
          end else begin
            wait_cnt_next = wait_cnt - P'(1);
          end
        end
      end

      default: state_next = S_IDLE;
    endcase

    // done is registered but tracks the state exactly.
    done_next = (state_next == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      wait_cnt  <= '0;
      error     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
      wait_cnt  <= wait_cnt_next;
      error     <= error_next;
      done      <= done_next;
    end
  end

endmodule
